// File: rtl/i2s_tx.sv
// Left-justified stereo serializer: one-entry sample holding register feeding a BCLK/LRCLK/SDATA shifter.
// Optional I2S_TX_HOLD_LAST_EN repeats the last transmitted pair on underrun instead of sending zeros.
module i2s_tx #(
    parameter int DATA_W    = 16,
    parameter int BCLK_HALF = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fs_in,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_left,
    input  logic [DATA_W-1:0] s_right,
    output logic              bclk,
    output logic              lrclk,
    output logic              sdata,
    output logic              frame_start,
    output logic              underrun,
    output logic              frame_err
);

    localparam int FRAME_BITS = 2 * DATA_W;
    localparam int HC_W       = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam int BC_W       = $clog2(FRAME_BITS + 1);
    localparam logic [HC_W-1:0] HC_LAST  = HC_W'(BCLK_HALF - 1);
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(FRAME_BITS - 1);
    localparam logic [BC_W-1:0] BC_RIGHT = BC_W'(DATA_W);

    // state | meaning
    // IDLE  | waiting for fs_in rising edge; bclk/sdata parked low
    // SHIFT | serializing the loaded pair, 2*DATA_W bclk periods
    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_fs_q;
    logic                  r_buf_full;
    logic                  r_consume;
    logic [DATA_W-1:0]     r_left;
    logic [DATA_W-1:0]     r_right;
    logic [FRAME_BITS-1:0] r_sh;
    logic [HC_W-1:0]       r_hcnt;
    logic [BC_W-1:0]       r_bit_cnt;
    logic                  r_bclk;
    logic                  r_lrclk;
    logic                  r_frame_start;
    logic                  r_underrun;
    logic                  r_frame_err;

    logic                  w_edge;
    logic                  w_xfer;
    logic                  w_load;
    logic                  w_wrap;
    logic                  w_fall;
    logic                  w_last_fall;
    logic [BC_W-1:0]       w_bit_nxt;
    logic [FRAME_BITS-1:0] w_fallback;
    logic [FRAME_BITS-1:0] w_frame_word;

    assign w_edge       = fs_in & ~r_fs_q;
    assign w_xfer       = s_valid & ~r_buf_full;
    assign w_load       = (r_state == IDLE) & w_edge;
    assign w_wrap       = (r_state == SHIFT) & (r_hcnt == HC_LAST);
    assign w_fall       = w_wrap & r_bclk;
    assign w_last_fall  = w_fall & (r_bit_cnt == BC_LAST);
    assign w_bit_nxt    = r_bit_cnt + 1'b1;
    assign w_frame_word = r_buf_full ? {r_left, r_right} : w_fallback;

`ifdef I2S_TX_HOLD_LAST_EN
    logic [FRAME_BITS-1:0] r_fallback;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fallback <= '0;
        end else if (w_load) begin
            r_fallback <= w_frame_word;
        end
    end

    assign w_fallback = r_fallback;
`else
    assign w_fallback = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_edge)      w_state_nxt = SHIFT;
            SHIFT:   if (w_last_fall) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fs_q        <= 1'b1;
            r_buf_full    <= 1'b0;
            r_consume     <= 1'b0;
            r_left        <= '0;
            r_right       <= '0;
            r_sh          <= '0;
            r_hcnt        <= '0;
            r_bit_cnt     <= '0;
            r_bclk        <= 1'b0;
            r_lrclk       <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            r_fs_q        <= fs_in;
            r_frame_start <= w_load;
            r_underrun    <= w_load & ~r_buf_full;
            r_frame_err   <= (r_state == SHIFT) & w_edge;
            // Buffer reopens one cycle after the load that consumed it.
            r_consume     <= w_load & r_buf_full;
            if (w_xfer) begin
                r_buf_full <= 1'b1;
                r_left     <= s_left;
                r_right    <= s_right;
            end else if (r_consume) begin
                r_buf_full <= 1'b0;
            end
            if (w_load) begin
                r_sh      <= w_frame_word;
                r_hcnt    <= '0;
                r_bit_cnt <= '0;
                r_bclk    <= 1'b0;
                r_lrclk   <= 1'b0;
            end else if (r_state == SHIFT) begin
                r_hcnt <= w_wrap ? '0 : r_hcnt + 1'b1;
                if (w_wrap) begin
                    r_bclk <= ~r_bclk;
                end
                if (w_fall) begin
                    r_sh      <= {r_sh[FRAME_BITS-2:0], 1'b0};
                    r_bit_cnt <= w_bit_nxt;
                    r_lrclk   <= (w_bit_nxt >= BC_RIGHT);
                end
            end
        end
    end

    assign s_ready     = ~r_buf_full;
    assign bclk        = r_bclk;
    assign lrclk       = r_lrclk;
    assign sdata       = (r_state == SHIFT) & r_sh[FRAME_BITS-1];
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;
    assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: per-cycle frame waveform model (bit slots, bclk phase, lrclk half) plus serial word capture.
module tb_i2s_tx;

    localparam int DW    = 16;
    localparam int BH    = 3;
    localparam int FRAME = 4 * DW * BH;

    logic          clk = 1'b0;
    logic          rst;
    logic          fs_in;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_left;
    logic [DW-1:0] s_right;
    logic          bclk;
    logic          lrclk;
    logic          sdata;
    logic          frame_start;
    logic          underrun;
    logic          frame_err;

    int checks = 0;
    int errors = 0;

    // model: buffered pair and pair an underrun would transmit
    bit            model_full = 1'b0;
    logic [DW-1:0] model_l;
    logic [DW-1:0] model_r;
    logic [2*DW-1:0] last_pair = '0;

    i2s_tx #(.DATA_W(DW), .BCLK_HALF(BH)) dut (
        .clk(clk), .rst(rst), .fs_in(fs_in), .s_valid(s_valid), .s_ready(s_ready),
        .s_left(s_left), .s_right(s_right), .bclk(bclk), .lrclk(lrclk), .sdata(sdata),
        .frame_start(frame_start), .underrun(underrun), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] obs;
        rst = 1'b1; fs_in = 1'b1; s_valid = 1'b0; s_left = '0; s_right = '0;
        repeat (3) step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 20; i++) begin
            obs = {frame_start, bclk, lrclk, sdata, s_ready, underrun, frame_err};
            checks++;
            if (obs !== 7'b0000100)
                $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, obs, 7'b0000100);
            step();
        end
        fs_in = 1'b0;
        step();
        model_full = 1'b0;
        last_pair  = '0;
    endtask

    task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
        int n;
        n = 0;
        s_left = l; s_right = r; s_valid = 1'b1;
        while (s_ready !== 1'b1 && n < 500) begin
            step();
            n++;
        end
        checks++;
        if (s_ready !== 1'b1) begin
            $display("FAIL push_wait got s_ready=%b exp=1 (timeout)", s_ready);
            errors++;
        end
        step();
        s_valid = 1'b0;
        checks++;
        if (s_ready !== 1'b0) begin
            $display("FAIL push_ready_drop got=%b exp=0", s_ready);
            errors++;
        end
        model_full = 1'b1;
        model_l = l;
        model_r = r;
    endtask

    task automatic run_frame(input int err_k);
        logic [2*DW-1:0] exp_pair;
        logic [2*DW-1:0] got;
        bit              exp_under;
        logic            prev_bclk;
        logic [2:0]      obs_p;
        logic [2:0]      exp_p;
        exp_under = !model_full;
        exp_pair  = model_full ? {model_l, model_r} : last_pair;
        got       = '0;
        prev_bclk = 1'b0;
        fs_in = 1'b1;
        step();
        for (int k = 0; k < FRAME; k++) begin
            obs_p = {frame_start, underrun, frame_err};
            exp_p = {k == 0, exp_under && k == 0, err_k >= 0 && k == err_k + 1};
            checks++;
            if (obs_p !== exp_p) begin
                $display("FAIL pulses k=%0d got=%b exp=%b", k, obs_p, exp_p);
                errors++;
            end
            checks++;
            if (bclk !== (((k / BH) % 2) == 1)) begin
                $display("FAIL bclk k=%0d got=%b", k, bclk);
                errors++;
            end
            checks++;
            if (lrclk !== (k >= 2 * DW * BH)) begin
                $display("FAIL lrclk k=%0d got=%b", k, lrclk);
                errors++;
            end
            checks++;
            if (sdata !== exp_pair[2*DW-1 - k/(2*BH)]) begin
                $display("FAIL sdata k=%0d got=%b exp=%b", k, sdata, exp_pair[2*DW-1 - k/(2*BH)]);
                errors++;
            end
            if (k <= 1) begin
                checks++;
                if (s_ready !== ((k == 1) || exp_under)) begin
                    $display("FAIL ready_reopen k=%0d got=%b exp=%b", k, s_ready, (k == 1) || exp_under);
                    errors++;
                end
            end
            if (bclk === 1'b1 && prev_bclk === 1'b0) got = {got[2*DW-2:0], sdata};
            prev_bclk = bclk;
            if (k == 2) fs_in = 1'b0;
            if (k == err_k) fs_in = 1'b1;
            if (k == err_k + 1) fs_in = 1'b0;
            step();
        end
        checks++;
        if (got !== exp_pair) begin
            $display("FAIL serial_word got=%h exp=%h", got, exp_pair);
            errors++;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({bclk, sdata, lrclk, frame_start} !== 4'b0010) begin
                $display("FAIL idle_after cyc=%0d got=%b exp=0010", i, {bclk, sdata, lrclk, frame_start});
                errors++;
            end
            step();
        end
        model_full = 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
        last_pair = exp_pair;
`endif
    endtask

    task automatic test_basic();
        push(16'hA5C3, 16'h0F0F);
        run_frame(-1);
    endtask

    task automatic test_underrun();
        run_frame(-1);
    endtask

    task automatic test_hold_full();
        push(DW'($urandom), DW'($urandom));
        s_valid = 1'b1; s_left = 16'h1111; s_right = 16'h2222;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (s_ready !== 1'b0) begin
                $display("FAIL hold_full cyc=%0d got s_ready=%b exp=0", i, s_ready);
                errors++;
            end
        end
        s_valid = 1'b0;
        run_frame(-1);
    endtask

    task automatic test_frame_err();
        push(DW'($urandom), DW'($urandom));
        run_frame(100);
    endtask

    task automatic test_random();
        for (int f = 0; f < 8; f++) begin
            if ($urandom_range(0, 3) != 0) push(DW'($urandom), DW'($urandom));
            repeat ($urandom_range(0, 5)) step();
            run_frame(($urandom_range(0, 2) == 0) ? int'($urandom_range(8, 185)) : -1);
        end
    endtask

    task automatic test_rst_mid();
        logic [6:0] obs;
        push(16'hFFFF, 16'hFFFF);
        fs_in = 1'b1;
        step();
        for (int k = 0; k < 50; k++) begin
            if (k == 2) fs_in = 1'b0;
            step();
        end
        rst = 1'b1;
        step();
        obs = {bclk, lrclk, sdata, s_ready, frame_start, underrun, frame_err};
        checks++;
        if (obs !== 7'b0001000) begin
            $display("FAIL rst_mid got=%b exp=%b", obs, 7'b0001000);
            errors++;
        end
        rst = 1'b0;
        step();
        model_full = 1'b0;
        last_pair  = '0;
        run_frame(-1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_underrun();
        test_hold_full();
        test_frame_err();
        test_random();
        test_rst_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
